// File: rtl/n64_vdemux.sv
// N64 video demultiplexer: splits the multiplexed D bus into sync nibble
// and R/G/B words, publishing one pixel per nDSYNC-low edge.
module n64_vdemux #(
   parameter int color_width = 7
) (
   input  logic                       nCLK,
   input  logic                       nRST,
   input  logic                       nDSYNC,
   input  logic [color_width-1:0]     D_i,
   input  logic [4:0]                 vinfo_i,
   input  logic                       nDeBlur,
   input  logic                       n15bit_mode,
   output logic [3:0]                 Sync_pre,
   output logic [3+3*color_width:0]   vdata_o,
   output logic                       vdata_valid
);

   localparam int CW = color_width;

   logic [1:0]    w_cnt;
   logic          w_480i;
   logic          w_blur;
   logic          w_unused;
   logic          w_hold;
   logic [CW-1:0] w_mask;

   logic [CW-1:0] r_R;
   logic [CW-1:0] r_G;
   logic [CW-1:0] r_B;

   assign w_cnt    = vinfo_i[4:3];
   assign w_480i   = vinfo_i[2];
   assign w_unused = vinfo_i[1];
   assign w_blur   = vinfo_i[0];

   // blurry pixels of a de-blurred 240p frame repeat the previous colour
   assign w_hold = !nDeBlur && !w_480i && w_blur;
   assign w_mask = n15bit_mode ? {CW{1'b1}}
                               : {{(CW-2){1'b1}}, 2'b00};

   always_ff @(negedge nCLK) begin
      if (!nRST) begin
         Sync_pre    <= 4'hF;
         vdata_o     <= {4'hF, {(3*CW){1'b0}}};
         vdata_valid <= 1'b0;
         r_R         <= '0;
         r_G         <= '0;
         r_B         <= '0;
      end else begin
         vdata_valid <= 1'b0;
         if (!nDSYNC) begin
            Sync_pre               <= D_i[3:0];
            vdata_valid            <= 1'b1;
            vdata_o[3+3*CW -: 4]   <= D_i[3:0];
            if (!w_hold)
               vdata_o[3*CW-1:0] <= {r_R & w_mask,
                                     r_G & w_mask,
                                     r_B & w_mask};
         end else begin
            unique case (w_cnt)
               2'b01:   r_R <= D_i;
               2'b10:   r_G <= D_i;
               2'b11:   r_B <= D_i;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_n64_vdemux.sv
// Self-checking bench for n64_vdemux: a pixel-level model checked on
// every cycle plus hand-computed expectations for the key scenarios.
module tb_n64_vdemux;

   logic        nCLK = 1'b1;
   logic        nRST = 1'b0;
   logic        nDSYNC = 1'b1;
   logic [6:0]  D_i = '0;
   logic [4:0]  vinfo_i = '0;
   logic        nDeBlur = 1'b1;
   logic        n15bit_mode = 1'b1;
   logic [3:0]  Sync_pre;
   logic [24:0] vdata_o;
   logic        vdata_valid;

   logic       i480 = 1'b1;
   logic       blurry = 1'b0;
   int         n_pass = 0;
   int         n_total = 0;
   bit         chk_en = 1'b0;
   int         strobes = 0;

   // model state: colours captured so far, and the pixel last published
   logic [6:0] col [3];
   logic [3:0] e_sync;
   logic [3:0] e_s;
   logic [6:0] e_rgb [3];
   logic       e_valid;

   n64_vdemux dut (
      .nCLK        (nCLK),
      .nRST        (nRST),
      .nDSYNC      (nDSYNC),
      .D_i         (D_i),
      .vinfo_i     (vinfo_i),
      .nDeBlur     (nDeBlur),
      .n15bit_mode (n15bit_mode),
      .Sync_pre    (Sync_pre),
      .vdata_o     (vdata_o),
      .vdata_valid (vdata_valid)
   );

   always #5 nCLK = ~nCLK;

   function automatic logic [24:0] e_vdata();
      return {e_s, e_rgb[0], e_rgb[1], e_rgb[2]};
   endfunction

   task automatic chk(input string name, input logic [24:0] act,
                      input logic [24:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   task automatic model_edge(input logic rst, input logic nd,
                             input logic [6:0] d, input logic [1:0] cnt);
      if (!rst) begin
         e_sync = 4'hF; e_s = 4'hF; e_valid = 1'b0;
         for (int k = 0; k < 3; k++) begin
            col[k] = '0; e_rgb[k] = '0;
         end
      end else if (!nd) begin
         e_sync = d[3:0]; e_s = d[3:0]; e_valid = 1'b1;
         if (!(nDeBlur == 1'b0 && i480 == 1'b0 && blurry))
            for (int k = 0; k < 3; k++)
               e_rgb[k] = n15bit_mode ? col[k] : (col[k] & 7'h7C);
      end else begin
         e_valid = 1'b0;
         if (cnt != 2'b00) col[cnt - 1] = d;
      end
   endtask

   // one falling edge with the given inputs; returns just after the edge
   task automatic drive(input logic rst, input logic nd,
                        input logic [6:0] d, input logic [1:0] cnt);
      @(posedge nCLK);
      #1;
      nRST = rst; nDSYNC = nd; D_i = d;
      vinfo_i = {cnt, i480, 1'b0, blurry};
      @(negedge nCLK);
      model_edge(rst, nd, d, cnt);
      #1;
      if (vdata_valid) strobes++;
   endtask

   task automatic pixel(input logic [6:0] r, input logic [6:0] g,
                        input logic [6:0] b, input logic [6:0] s);
      drive(1, 1, r, 2'b01);
      drive(1, 1, g, 2'b10);
      drive(1, 1, b, 2'b11);
      drive(1, 0, s, 2'b00);
   endtask

   always @(posedge nCLK) begin
      if (chk_en) begin
         chk("model_sync", {21'b0, Sync_pre}, {21'b0, e_sync});
         chk("model_vdata", vdata_o, e_vdata());
         chk("model_valid", {24'b0, vdata_valid}, {24'b0, e_valid});
      end
   end

   initial begin
      drive(0, 1, 7'h00, 2'b00);
      drive(0, 1, 7'h00, 2'b00);
      chk_en = 1'b1;
      chk("rst_sync", {21'b0, Sync_pre}, 25'h0F);
      chk("rst_vdata", vdata_o, {4'hF, 21'h0});
      chk("rst_valid", {24'b0, vdata_valid}, 25'h0);

      drive(1, 0, 7'h0F, 2'b00);
      pixel(7'h55, 7'h2A, 7'h7F, 7'h0E);
      chk("basic_vdata", vdata_o, {4'hE, 7'h55, 7'h2A, 7'h7F});
      chk("basic_valid", {24'b0, vdata_valid}, 25'h1);
      chk("basic_sync", {21'b0, Sync_pre}, 25'h0E);
      drive(1, 1, 7'h00, 2'b00);
      chk("idle_valid", {24'b0, vdata_valid}, 25'h0);
      chk("idle_hold", vdata_o, {4'hE, 7'h55, 7'h2A, 7'h7F});

      n15bit_mode = 1'b0;
      pixel(7'h55, 7'h2A, 7'h7F, 7'h0E);
      chk("m15_vdata", vdata_o, {4'hE, 7'h54, 7'h28, 7'h7C});
      n15bit_mode = 1'b1;
      drive(1, 0, 7'h0C, 2'b00);
      chk("m15_unmasked", vdata_o, {4'hC, 7'h55, 7'h2A, 7'h7F});

      nDeBlur = 1'b0; i480 = 1'b0; blurry = 1'b1;
      pixel(7'h11, 7'h22, 7'h33, 7'h0D);
      chk("deblur_hold", vdata_o, {4'hD, 7'h55, 7'h2A, 7'h7F});
      i480 = 1'b1;
      pixel(7'h11, 7'h22, 7'h33, 7'h0B);
      chk("deblur_480i", vdata_o, {4'hB, 7'h11, 7'h22, 7'h33});
      nDeBlur = 1'b1; blurry = 1'b0;

      drive(1, 0, 7'h7C, 2'b01);
      chk("prec_sync", {21'b0, Sync_pre}, 25'h0C);
      drive(1, 0, 7'h0A, 2'b00);
      chk("prec_rgb", vdata_o, {4'hA, 7'h11, 7'h22, 7'h33});

      drive(1, 1, 7'h55, 2'b01);
      drive(0, 1, 7'h00, 2'b00);
      chk("mid_rst_vdata", vdata_o, {4'hF, 21'h0});
      drive(1, 1, 7'h2A, 2'b10);
      drive(1, 1, 7'h7F, 2'b11);
      chk("mid_rst_sync", {21'b0, Sync_pre}, 25'h0F);
      drive(1, 0, 7'h0E, 2'b00);
      chk("mid_rst_pix", vdata_o, {4'hE, 7'h00, 7'h2A, 7'h7F});

      drive(1, 1, 7'h01, 2'b01);
      drive(1, 1, 7'h02, 2'b10);
      drive(1, 1, 7'h03, 2'b11);
      strobes = 0;
      drive(1, 0, 7'h0F, 2'b00);
      chk("b2b_0", vdata_o, {4'hF, 7'h01, 7'h02, 7'h03});
      drive(1, 0, 7'h0D, 2'b00);
      chk("b2b_1", vdata_o, {4'hD, 7'h01, 7'h02, 7'h03});
      drive(1, 0, 7'h0F, 2'b00);
      chk("b2b_2", vdata_o, {4'hF, 7'h01, 7'h02, 7'h03});
      drive(1, 1, 7'h00, 2'b00);
      chk("b2b_strobes", 25'(strobes), 25'd3);

      @(posedge nCLK);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
